rf_write_arbiter: RTL and testbench

//   Shares the register file's single write port (rW/w/WE) between the pipeline

---
 rtl/rf_write_arbiter.sv | 126 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, multi-cycle results
// wait in a small FIFO and drain on idle WB cycles, with busy flags and a starvation hold.
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  parameter bit DROP_R0      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_w,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rw,
  input  logic [31:0] mc_w,
  output logic        mc_ready,
  input  logic [4:0]  q_ra,
  input  logic [4:0]  q_rb,
  output logic        busy_a,
  output logic        busy_b,
  output logic        wb_hold,
  output logic        rf_WE,
  output logic [4:0]  rf_rW,
  output logic [31:0] rf_w
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]       ent_rw [DEPTH];
  logic [31:0]      ent_w  [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt, starve_nxt;

  logic empty, full, push, pop, sel_we;
  logic [4:0] sel_rw;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Handshake: an MC result transfers on a posedge where mc_valid && mc_ready;
  // mc_ready depends only on FIFO fullness (and reset), never on mc_valid, and
  // a pop in the same cycle does not free a slot for that cycle's push.
  assign mc_ready = !full && !rst;
  assign push     = mc_valid && mc_ready;
  assign pop      = !wb_we && !empty;

  // Write mux: WB first, then the FIFO head; r0 writes are suppressed but still pop.
  always_comb begin
    sel_we = 1'b0;
    sel_rw = '0;
    rf_w   = '0;
    if (wb_we) begin
      sel_we = 1'b1;
      sel_rw = wb_rw;
      rf_w   = wb_w;
    end else if (!empty) begin
      sel_we = 1'b1;
      sel_rw = ent_rw[rd_ptr];
      rf_w   = ent_w[rd_ptr];
    end
  end

  assign rf_rW = sel_rw;
  assign rf_WE = sel_we && !rst && !(DROP_R0 && (sel_rw == 5'd0));

  // Busy covers every queued entry, including a head that is draining this cycle.
  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rw[i] == q_ra)) busy_a = 1'b1;
      if (ent_valid[i] && (ent_rw[i] == q_rb)) busy_b = 1'b1;
    end
    if (DROP_R0 && (q_ra == 5'd0)) busy_a = 1'b0;
    if (DROP_R0 && (q_rb == 5'd0)) busy_b = 1'b0;
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || empty)
      starve_nxt = '0;
    else if (wb_we && (starve_cnt != STARVE_MAX))
      starve_nxt = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ent_valid  <= '0;
      starve_cnt <= '0;
      wb_hold    <= 1'b0;
    end else begin
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      starve_cnt <= starve_nxt;
      wb_hold    <= (starve_nxt == STARVE_MAX);
    end
  end

  // Payload storage needs no reset; validity is tracked by ent_valid/count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rw[wr_ptr] <= mc_rw;
      ent_w[wr_ptr]  <= mc_w;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: WB priority, FIFO ordering/full,
// starvation hold, r0 drop and mid-operation reset.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_w;
  logic        mc_valid;
  logic [4:0]  mc_rw;
  logic [31:0] mc_w;
  logic        mc_ready;
  logic [4:0]  q_ra, q_rb;
  logic        busy_a, busy_b;
  logic        wb_hold;
  logic        rf_WE;
  logic [4:0]  rf_rW;
  logic [31:0] rf_w;

  int total = 0;
  int bad   = 0;

  rf_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4), .DROP_R0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_w(wb_w),
    .mc_valid(mc_valid), .mc_rw(mc_rw), .mc_w(mc_w), .mc_ready(mc_ready),
    .q_ra(q_ra), .q_rb(q_rb), .busy_a(busy_a), .busy_b(busy_b),
    .wb_hold(wb_hold), .rf_WE(rf_WE), .rf_rW(rf_rW), .rf_w(rf_w)
  );

  always #5 clk = ~clk;

  // Advance one posedge, then settle inputs/outputs away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [4:0] rw, input logic [31:0] w);
    wb_we = we; wb_rw = rw; wb_w = w;
  endtask

  task automatic mc(input logic v, input logic [4:0] rw, input logic [31:0] w);
    mc_valid = v; mc_rw = rw; mc_w = w;
  endtask

  initial begin
    rst = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    mc(1'b0, 5'd0, 32'h0);
    q_ra = 5'd0; q_rb = 5'd0;
    #2;
    chk("rst_mc_ready", {31'b0, mc_ready}, 32'd0);
    chk("rst_rf_we", {31'b0, rf_WE}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;

    // 1: idle after reset
    q_ra = 5'd6; q_rb = 5'd7;
    chk("t1_rf_we", {31'b0, rf_WE}, 32'd0);
    chk("t1_mc_ready", {31'b0, mc_ready}, 32'd1);
    chk("t1_busy_a", {31'b0, busy_a}, 32'd0);
    chk("t1_busy_b", {31'b0, busy_b}, 32'd0);
    chk("t1_wb_hold", {31'b0, wb_hold}, 32'd0);

    // 2: WB wins same cycle, MC follows one cycle later
    wb(1'b1, 5'd5, 32'h1234);
    mc(1'b1, 5'd6, 32'hBEEF);
    #1;
    chk("t2_wb_we", {31'b0, rf_WE}, 32'd1);
    chk("t2_wb_rw", {27'b0, rf_rW}, 32'd5);
    chk("t2_wb_w", rf_w, 32'h1234);
    chk("t2_busy_pre", {31'b0, busy_a}, 32'd0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    mc(1'b0, 5'd0, 32'h0);
    #1;
    chk("t2_busy6", {31'b0, busy_a}, 32'd1);
    chk("t2_mc_we", {31'b0, rf_WE}, 32'd1);
    chk("t2_mc_rw", {27'b0, rf_rW}, 32'd6);
    chk("t2_mc_w", rf_w, 32'hBEEF);
    step();
    chk("t2_busy_clr", {31'b0, busy_a}, 32'd0);
    chk("t2_idle_we", {31'b0, rf_WE}, 32'd0);

    // 3: fill FIFO under WB pressure, then drain in order
    wb(1'b1, 5'd1, 32'h11);
    mc(1'b1, 5'd7, 32'h70);
    step();
    mc(1'b1, 5'd8, 32'h80);
    #1;
    chk("t3_ready_1", {31'b0, mc_ready}, 32'd1);
    step();
    mc(1'b1, 5'd9, 32'h90);
    #1;
    chk("t3_ready_full", {31'b0, mc_ready}, 32'd0);
    step();
    q_ra = 5'd7; q_rb = 5'd8;
    #1;
    chk("t3_still_full", {31'b0, mc_ready}, 32'd0);
    chk("t3_busy7", {31'b0, busy_a}, 32'd1);
    chk("t3_busy8", {31'b0, busy_b}, 32'd1);
    chk("t3_wb_rw", {27'b0, rf_rW}, 32'd1);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("t3_head7_rw", {27'b0, rf_rW}, 32'd7);
    chk("t3_head7_w", rf_w, 32'h70);
    chk("t3_full_pop_ready", {31'b0, mc_ready}, 32'd0);
    step();
    chk("t3_ready_after_pop", {31'b0, mc_ready}, 32'd1);
    chk("t3_head8_rw", {27'b0, rf_rW}, 32'd8);
    chk("t3_head8_w", rf_w, 32'h80);
    chk("t3_busy7_clr", {31'b0, busy_a}, 32'd0);
    step();
    mc(1'b0, 5'd0, 32'h0);
    #1;
    chk("t3_head9_rw", {27'b0, rf_rW}, 32'd9);
    chk("t3_head9_w", rf_w, 32'h90);
    chk("t3_head9_we", {31'b0, rf_WE}, 32'd1);
    step();
    chk("t3_drained", {31'b0, rf_WE}, 32'd0);
    chk("t3_hold", {31'b0, wb_hold}, 32'd0);

    // 4: starvation hold after 4 blocked cycles, cleared by a pop
    wb(1'b1, 5'd2, 32'h22);
    mc(1'b1, 5'd10, 32'hA);
    step();
    mc(1'b0, 5'd0, 32'h0);
    step();
    step();
    step();
    chk("t4_hold_3", {31'b0, wb_hold}, 32'd0);
    step();
    chk("t4_hold_4", {31'b0, wb_hold}, 32'd1);
    chk("t4_wb_wins", {27'b0, rf_rW}, 32'd2);
    step();
    chk("t4_hold_sat", {31'b0, wb_hold}, 32'd1);
    wb(1'b0, 5'd0, 32'h0);
    #1;
    chk("t4_pop_rw", {27'b0, rf_rW}, 32'd10);
    chk("t4_pop_we", {31'b0, rf_WE}, 32'd1);
    step();
    chk("t4_hold_clr", {31'b0, wb_hold}, 32'd0);
    chk("t4_empty", {31'b0, rf_WE}, 32'd0);

    // 5: r0 entry pops without writing
    mc(1'b1, 5'd0, 32'hFFFF);
    step();
    mc(1'b1, 5'd3, 32'h33);
    q_ra = 5'd0;
    #1;
    chk("t5_r0_we", {31'b0, rf_WE}, 32'd0);
    chk("t5_r0_busy", {31'b0, busy_a}, 32'd0);
    step();
    mc(1'b0, 5'd0, 32'h0);
    #1;
    chk("t5_next_rw", {27'b0, rf_rW}, 32'd3);
    chk("t5_next_w", rf_w, 32'h33);
    step();
    chk("t5_empty", {31'b0, rf_WE}, 32'd0);

    // 6: async reset discards queued entries
    wb(1'b1, 5'd4, 32'h44);
    mc(1'b1, 5'd12, 32'hC);
    step();
    mc(1'b1, 5'd13, 32'hD);
    step();
    mc(1'b0, 5'd0, 32'h0);
    q_ra = 5'd12; q_rb = 5'd13;
    #1;
    chk("t6_busy12", {31'b0, busy_a}, 32'd1);
    chk("t6_busy13", {31'b0, busy_b}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", {31'b0, mc_ready}, 32'd0);
    chk("t6_rst_busy_a", {31'b0, busy_a}, 32'd0);
    chk("t6_rst_busy_b", {31'b0, busy_b}, 32'd0);
    chk("t6_rst_we", {31'b0, rf_WE}, 32'd0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    #1;
    chk("t6_post_we", {31'b0, rf_WE}, 32'd0);
    chk("t6_post_ready", {31'b0, mc_ready}, 32'd1);
    chk("t6_post_busy", {31'b0, busy_a}, 32'd0);
    step();
    chk("t6_post_we2", {31'b0, rf_WE}, 32'd0);
    chk("t6_post_hold", {31'b0, wb_hold}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
